rmii_frame_tx: RTL and testbench

- Downstream stage of the matrix compiler, in the eth_refclk domain.
- Consumes the compiler's serialized dibit stream (MSB-dibit-first bytes, one dibit per cycle) and emits a complete Ethernet II frame on the RMII transmit pins: preamble, SFD, fixed header, PAYLOAD_BYTES payload bytes, CRC-32 FCS, then inter-packet gap.
- A small byte FIFO absorbs the incoming payload while preamble and header go out.

---
 rtl/rmii_frame_tx_if.sv | 21 ++
 rtl/rmii_frame_tx.sv | 219 +++++++++++++++++++++
 tb/tb_rmii_frame_tx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_frame_tx_if.sv
// Payload dibit stream into the RMII framer and the transmit pins / status coming out.
interface rmii_frame_tx_if;
  logic [1:0] dibit_in;
  logic       valid_in;
  logic [1:0] txd;
  logic       txen;
  logic       busy;
  logic       frame_done;
  logic       err_underflow;
  logic       err_overflow;

  modport master (
    output dibit_in, valid_in,
    input  txd, txen, busy, frame_done, err_underflow, err_overflow
  );

  modport slave (
    input  dibit_in, valid_in,
    output txd, txen, busy, frame_done, err_underflow, err_overflow
  );
endinterface

// File: rtl/rmii_frame_tx.sv
// Wraps the compiler's dibit stream into an Ethernet II frame on RMII transmit pins.
// state    | meaning
// IDLE     | txen low, waiting for the first payload dibit
// PREAMBLE | 28 dibits of 01
// SFD      | 01 01 01 11
// HEADER   | destination MAC, source MAC, EtherType (56 dibits)
// PAYLOAD  | FIFO bytes, one pop every 4 dibits
// FCS      | inverted CRC, 16 dibits
// IPG      | txen low for the inter-packet gap
module rmii_frame_tx #(
  parameter int          PAYLOAD_BYTES = 1024,
  parameter int          FIFO_DEPTH    = 32,
  parameter logic [47:0] DEST_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          IPG_DIBITS    = 48
) (
  input logic            eth_refclk,
  input logic            rst_n,
  rmii_frame_tx_if.slave tx
);
  localparam int PAY_DIBITS = PAYLOAD_BYTES * 4;
  localparam int CW         = 16;
  localparam int AW         = $clog2(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_HEADER   = 3'd3;
  localparam logic [2:0] ST_PAYLOAD  = 3'd4;
  localparam logic [2:0] ST_FCS      = 3'd5;
  localparam logic [2:0] ST_IPG      = 3'd6;

  // Byte-reversed header so that dibit h of the wire order sits at bits [2h+1:2h].
  function automatic logic [111:0] hdr_wire_order(input logic [111:0] h);
    logic [111:0] r;
    r = '0;
    for (int k = 0; k < 14; k++) r[8*k +: 8] = h[111-8*k -: 8];
    return r;
  endfunction

  localparam logic [111:0] HDR_WIRE = hdr_wire_order({DEST_MAC, SRC_MAC, ETHERTYPE});

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] acc_rem;
  logic [31:0]   crc;
  logic [31:0]   crc_nx;
  logic [31:0]   fcs_sr;
  logic [7:0]    tx_byte;
  logic [5:0]    asm_sr;
  logic [1:0]    asm_cnt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nx;
  logic [7:0]    rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          in_window;
  logic          push_slot;
  logic          accept;
  logic          push;
  logic          drop;
  logic          pop_need;
  logic          pop;
  logic          underflow;
  logic [1:0]    txd_c;
  logic          txen_c;
  logic [5:0]    hdr_pos;
  logic          err_underflow_q;
  logic          err_overflow_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
  assign rd_data    = fifo_mem[rd_ptr[AW-1:0]];

  always_comb begin
    in_window = 1'b0;
    case (state)
      ST_IDLE:                                    in_window = 1'b1;
      ST_PREAMBLE, ST_SFD, ST_HEADER, ST_PAYLOAD: in_window = (acc_rem != '0);
      default:                                    in_window = 1'b0;
    endcase
  end

  // A dibit that would complete a byte into a full FIFO is dropped, assembler untouched.
  assign push_slot = (asm_cnt == 2'd3);
  assign accept    = tx.valid_in && in_window && !(push_slot && fifo_full);
  assign drop      = tx.valid_in && !accept;
  assign push      = accept && push_slot;
  assign wr_ptr_nx = push ? wr_ptr + (AW+1)'(1) : wr_ptr;

  assign pop_need  = (state == ST_HEADER && cnt == '0) ||
                     (state == ST_PAYLOAD && cnt[1:0] == 2'b00 && cnt != '0);
  assign underflow = pop_need && fifo_empty;
  assign pop       = pop_need && !fifo_empty;

  assign hdr_pos = 6'd55 - cnt[5:0];

  always_comb begin
    txd_c  = 2'b00;
    txen_c = 1'b0;
    case (state)
      ST_PREAMBLE: begin txen_c = 1'b1; txd_c = 2'b01; end
      ST_SFD:      begin txen_c = 1'b1; txd_c = (cnt == '0) ? 2'b11 : 2'b01; end
      ST_HEADER:   begin txen_c = 1'b1; txd_c = HDR_WIRE[{hdr_pos, 1'b0} +: 2]; end
      ST_PAYLOAD:  begin txen_c = 1'b1; txd_c = tx_byte[1:0]; end
      ST_FCS:      begin txen_c = 1'b1; txd_c = fcs_sr[1:0]; end
      default:     begin txen_c = 1'b0; txd_c = 2'b00; end
    endcase
  end

  always_comb begin
    crc_nx = crc;
    for (int i = 0; i < 2; i++) begin
      if (crc_nx[0] ^ txd_c[i]) crc_nx = (crc_nx >> 1) ^ 32'hEDB8_8320;
      else                      crc_nx = crc_nx >> 1;
    end
  end

  always_ff @(posedge eth_refclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {asm_sr, tx.dibit_in};
  end

  always_ff @(posedge eth_refclk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      acc_rem         <= '0;
      crc             <= 32'hFFFF_FFFF;
      fcs_sr          <= '0;
      tx_byte         <= '0;
      asm_sr          <= '0;
      asm_cnt         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      err_overflow_q  <= drop;
      err_underflow_q <= underflow;
      wr_ptr          <= wr_ptr_nx;

      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        tx_byte <= rd_data;
      end else if (state == ST_PAYLOAD) begin
        tx_byte <= {2'b00, tx_byte[7:2]};
      end

      if (accept) begin
        asm_sr  <= {asm_sr[3:0], tx.dibit_in};
        asm_cnt <= asm_cnt + 2'd1;
        acc_rem <= (state == ST_IDLE) ? CW'(PAY_DIBITS - 1) : acc_rem - CW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_PREAMBLE;
            cnt   <= CW'(27);
            crc   <= 32'hFFFF_FFFF;
          end
        end
        ST_PREAMBLE: begin
          if (cnt == '0) begin state <= ST_SFD; cnt <= CW'(3); end
          else cnt <= cnt - CW'(1);
        end
        ST_SFD: begin
          if (cnt == '0) begin state <= ST_HEADER; cnt <= CW'(55); end
          else cnt <= cnt - CW'(1);
        end
        ST_HEADER: begin
          crc <= crc_nx;
          if (cnt == '0) begin state <= ST_PAYLOAD; cnt <= CW'(PAY_DIBITS - 1); end
          else cnt <= cnt - CW'(1);
        end
        ST_PAYLOAD: begin
          crc <= crc_nx;
          if (cnt == '0) begin
            state  <= ST_FCS;
            cnt    <= CW'(15);
            fcs_sr <= ~crc_nx;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FCS: begin
          fcs_sr <= {2'b00, fcs_sr[31:2]};
          if (cnt == '0) begin state <= ST_IPG; cnt <= CW'(IPG_DIBITS - 1); end
          else cnt <= cnt - CW'(1);
        end
        ST_IPG: begin
          if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - CW'(1);
        end
        default: state <= ST_IDLE;
      endcase

      // Starved FIFO: abandon the frame without FCS and discard whatever is left.
      if (underflow) begin
        state   <= ST_IPG;
        cnt     <= CW'(IPG_DIBITS - 1);
        rd_ptr  <= wr_ptr_nx;
        acc_rem <= '0;
        asm_sr  <= '0;
        asm_cnt <= '0;
      end
    end
  end

  assign tx.txd           = txd_c;
  assign tx.txen          = txen_c;
  assign tx.busy          = (state != ST_IDLE);
  assign tx.frame_done    = (state == ST_FCS) && (cnt == '0);
  assign tx.err_underflow = err_underflow_q;
  assign tx.err_overflow  = err_overflow_q;
endmodule

// File: tb/tb_rmii_frame_tx.sv
// Scoreboard bench for rmii_frame_tx: expected wire dibits are built from byte lists and popped by a monitor.
module tb_rmii_frame_tx;
  localparam int PB       = 1024;
  localparam int FULL_LEN = 28 + 4 + 56 + PB*4 + 16;
  localparam int IPG      = 48;

  logic eth_refclk = 1'b0;
  logic rst_n      = 1'b0;

  rmii_frame_tx_if tif();

  rmii_frame_tx #(.PAYLOAD_BYTES(PB)) dut (
    .eth_refclk (eth_refclk),
    .rst_n      (rst_n),
    .tx         (tif)
  );

  always #10 eth_refclk = ~eth_refclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge eth_refclk) cyc <= cyc + 1;

  logic [2:0] exp_q [$];
  int         len_q [$];
  int         gap_q [$];
  int         start_q [$];
  logic [7:0] pl [PB];
  logic [7:0] hdr_b [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                             8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                             8'h88, 8'hB5};
  int  uf_seen = 0, of_seen = 0, done_seen = 0;
  int  uf_exp = 0, of_exp = 0;
  bit  mon_en = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge eth_refclk);
    #1;
  endtask

  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    for (int i = 0; i < 2; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Frame length when the input stops after sent_bytes: byte j is ready at edge 4j+3, needed at 88+4j.
  function automatic int model_len(input int sent_bytes);
    for (int j = 0; j < PB; j++)
      if (j >= sent_bytes || 4*j + 3 >= 88 + 4*j) return 88 + 4*j;
    return FULL_LEN;
  endfunction

  task automatic push_expected(input int cut, input int gap);
    logic [7:0]  fb [$];
    logic [1:0]  d  [$];
    logic [31:0] c;
    logic [31:0] fcs;
    for (int k = 0; k < 14; k++) fb.push_back(hdr_b[k]);
    for (int k = 0; k < PB; k++) fb.push_back(pl[k]);
    c = 32'hFFFF_FFFF;
    foreach (fb[k]) begin
      c = c ^ {24'h0, fb[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
    repeat (31) d.push_back(2'b01);
    d.push_back(2'b11);
    foreach (fb[k]) for (int j = 0; j < 4; j++) d.push_back(2'(fb[k] >> (2*j)));
    for (int i = 0; i < cut; i++)
      exp_q.push_back({(cut == FULL_LEN && i == FULL_LEN - 1), d[i]});
    len_q.push_back(cut);
    gap_q.push_back(gap);
  endtask

  task automatic send_stream(input int n, input int extra, input int rst_at);
    logic [7:0] b;
    bit stop;
    stop = 0;
    start_q.push_back(cyc);
    for (int i = 0; i < n + extra && !stop; i++) begin
      if (i == rst_at) begin
        tif.valid_in = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_txen", tif.txen, 0);
        chk("rst_busy", tif.busy, 0);
        stop = 1;
      end else begin
        if (i < n) begin
          b = pl[i/4];
          tif.dibit_in = 2'(b >> (6 - 2*(i%4)));
        end else begin
          tif.dibit_in = 2'($urandom_range(0, 3));
        end
        tif.valid_in = 1'b1;
        tick();
      end
    end
    tif.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tif.busy && t < 10000) begin tick(); t++; end
    chk("wait_idle_in_budget", (t < 10000), 1);
    repeat (3) tick();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!tif.frame_done && t < 10000) begin tick(); t++; end
    chk("wait_done_in_budget", (t < 10000), 1);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < PB; i++) pl[i] = 8'($urandom);
  endtask

  initial begin : monitor
    bit          in_frame = 0;
    bit          prev_busy = 0;
    bit          saw_done = 0;
    int          flen = 0;
    int          gap_cnt = 0;
    int          el;
    int          st;
    logic [2:0]  e;
    logic [31:0] rc = 32'hFFFF_FFFF;
    forever begin
      @(negedge eth_refclk);
      if (mon_en) begin
        if (tif.err_underflow) uf_seen++;
        if (tif.err_overflow)  of_seen++;
        if (tif.txen) begin
          if (!in_frame) begin
            in_frame = 1; flen = 0; rc = 32'hFFFF_FFFF; saw_done = 0;
            chk("frame_start_expected", (start_q.size() > 0), 1);
            if (start_q.size() > 0) begin
              st = start_q.pop_front();
              chk("txen_latency", cyc - st, 1);
            end
          end
          chk("dibit_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("txd", tif.txd, e[1:0]);
            chk("frame_done", tif.frame_done, e[2]);
          end
          if (tif.frame_done) begin saw_done = 1; done_seen++; end
          if (flen >= 32) rc = crc2(rc, tif.txd);
          flen++;
        end else begin
          chk("idle_txd", tif.txd, 0);
          if (in_frame) begin
            in_frame = 0;
            chk("frame_len_expected", (len_q.size() > 0), 1);
            if (len_q.size() > 0) begin
              el = len_q.pop_front();
              chk("txen_cycles", flen, el);
              for (int k = flen; k < el; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (saw_done) chk("crc_residue", rc, 32'hDEBB_20E3);
          end
        end
        if (tif.busy && !tif.txen) gap_cnt++;
        if (prev_busy && !tif.busy) begin
          chk("gap_expected", (gap_q.size() > 0), 1);
          if (gap_q.size() > 0) chk("ipg_cycles", gap_cnt, gap_q.pop_front());
          gap_cnt = 0;
        end
        prev_busy = tif.busy;
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge eth_refclk);
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: actual timeout required finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : stimulus
    tif.dibit_in = 2'b00;
    tif.valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (5) begin
      tick();
      chk("reset_txd", tif.txd, 0);
      chk("reset_txen", tif.txen, 0);
      chk("reset_busy", tif.busy, 0);
      chk("reset_done", tif.frame_done, 0);
      chk("reset_uf", tif.err_underflow, 0);
      chk("reset_of", tif.err_overflow, 0);
    end
    rst_n = 1'b1;
    mon_en = 1;
    repeat (10) begin tick(); chk("idle_txen", tif.txen, 0); end

    // Counting payload
    for (int i = 0; i < PB; i++) pl[i] = 8'(i);
    push_expected(FULL_LEN, IPG);
    send_stream(PB*4, 0, -1);
    wait_idle();

    // Input stops at byte 500: FIFO starves
    rand_payload();
    push_expected(model_len(500), IPG);
    uf_exp++;
    send_stream(500*4, 0, -1);
    wait_idle();

    // Eight surplus dibits after the payload count
    rand_payload();
    push_expected(FULL_LEN, IPG);
    of_exp += 8;
    send_stream(PB*4, 8, -1);
    wait_idle();

    // Back-to-back frames, second starts as soon as IDLE is reached
    rand_payload();
    push_expected(FULL_LEN, IPG);
    send_stream(PB*4, 0, -1);
    wait_done();
    repeat (IPG + 1) tick();
    rand_payload();
    push_expected(FULL_LEN, IPG);
    send_stream(PB*4, 0, -1);
    wait_idle();

    // Reset while payload byte 100 is on the wire
    rand_payload();
    push_expected(88 + 400, 0);
    send_stream(PB*4, 0, 88 + 400);
    repeat (5) tick();

    rand_payload();
    push_expected(FULL_LEN, IPG);
    send_stream(PB*4, 0, -1);
    wait_idle();
    repeat (5) tick();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("len_q_drained", len_q.size(), 0);
    chk("underflow_pulses", uf_seen, uf_exp);
    chk("overflow_pulses", of_seen, of_exp);
    chk("frame_done_pulses", done_seen, 5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
